// File: rtl/pipe_defs.sv
// Shared pipeline definitions for the decode-side branch unit: opcode and
// funct constants, PC-select encodings, exception vector, bubble constant,
// the decode FSM state type and an opcode legality helper.
package pipe_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  localparam logic [1:0] PCSEL_BR  = 2'b00;
  localparam logic [1:0] PCSEL_REG = 2'b01;
  localparam logic [1:0] PCSEL_IDX = 2'b10;
  localparam logic [1:0] PCSEL_EXC = 2'b11;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0040;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } id_state_e;

  // Opcodes the decoder recognises; anything else raises an exception.
  function automatic logic op_known(input logic [5:0] op);
    logic known;
    case (op)
      6'd0, 6'd2, 6'd3, 6'd4, 6'd5,
      6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
      6'd35, 6'd43: known = 1'b1;
      default:      known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/id_branch_unit_if.sv
// IF/ID, register-file, PC-redirect and ID/EX signals of the decode branch
// unit. master = the branch unit, slave = the surrounding pipeline.
interface id_branch_unit_if #(
  parameter int ADDR_W = 5
);

  logic [31:0]       if_id_instruc;
  logic [31:0]       if_id_nextpc;
  logic              ex_if_stall;
  logic [ADDR_W-1:0] id_rf_addra;
  logic [ADDR_W-1:0] id_rf_addrb;
  logic [31:0]       rf_id_dataa;
  logic [31:0]       rf_id_datab;
  logic              id_if_selpcsource;
  logic [1:0]        id_if_selpctype;
  logic [31:0]       id_if_pcimd2ext;
  logic [31:0]       id_if_rega;
  logic [31:0]       id_if_pcindex;
  logic [31:0]       id_ex_instruc;
  logic [31:0]       id_ex_nextpc;
  logic              id_ex_link;
  logic              id_ex_exc;

  modport master (
    input  if_id_instruc, if_id_nextpc, ex_if_stall, rf_id_dataa, rf_id_datab,
    output id_rf_addra, id_rf_addrb, id_if_selpcsource, id_if_selpctype,
           id_if_pcimd2ext, id_if_rega, id_if_pcindex,
           id_ex_instruc, id_ex_nextpc, id_ex_link, id_ex_exc
  );

  modport slave (
    output if_id_instruc, if_id_nextpc, ex_if_stall, rf_id_dataa, rf_id_datab,
    input  id_rf_addra, id_rf_addrb, id_if_selpcsource, id_if_selpctype,
           id_if_pcimd2ext, id_if_rega, id_if_pcindex,
           id_ex_instruc, id_ex_nextpc, id_ex_link, id_ex_exc
  );

endinterface

// File: rtl/branch_target_gen.sv
// Combinational branch/jump target generator and register comparator.
// Targets wrap around at 32 bits; no overflow detection.
module branch_target_gen (
  input  logic [31:0] nextpc_i,
  input  logic [25:0] index_i,
  input  logic [31:0] dataa_i,
  input  logic [31:0] datab_i,
  output logic [31:0] pcimd2ext_o,
  output logic [31:0] pcindex_o,
  output logic        equal_o
);

  logic [31:0] offset_s;

  // Sign-extended immediate (low half of the index field) scaled to words.
  assign offset_s    = {{14{index_i[15]}}, index_i[15:0], 2'b00};
  assign pcimd2ext_o = nextpc_i + offset_s;
  assign pcindex_o   = {nextpc_i[31:28], index_i, 2'b00};
  assign equal_o     = (dataa_i == datab_i);

endmodule

// File: rtl/id_branch_unit.sv
// Decode-stage branch unit: resolves BEQ/BNE/J/JAL/JR/SYSCALL and illegal
// opcodes, drives the PC-redirect bus back to fetch and registers the
// instruction into the ID/EX latch. The shadow instruction following a
// redirect is squashed unless ID_BRANCH_DELAY_SLOT_EN is defined, in which
// case it executes as a delay slot.
module id_branch_unit
  import pipe_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = pipe_defs::EXC_VECTOR,
  parameter int          ADDR_W     = 5
) (
  input logic              clock,
  input logic              reset,
  id_branch_unit_if.master bus
);

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic        equal_s;
  logic [31:0] pcimd2ext_s;
  logic [31:0] pcindex_s;

  logic        dec_take_s;
  logic [1:0]  dec_type_s;
  logic        dec_link_s;
  logic        dec_exc_s;
  logic        redirect_ok_s;
  logic        selpcsource_s;
  logic [1:0]  selpctype_s;

  id_state_e   state_q, state_d;
  logic [31:0] instruc_q, instruc_d;
  logic [31:0] nextpc_q, nextpc_d;
  logic        link_q, link_d;
  logic        exc_q, exc_d;

  // The exception vector is hardwired in fetch; kept here for reference only.
  logic unused_exc_vector_s;
  assign unused_exc_vector_s = ^EXC_VECTOR;

  assign op_s    = bus.if_id_instruc[31:26];
  assign funct_s = bus.if_id_instruc[5:0];

  branch_target_gen u_tgen (
    .nextpc_i    (bus.if_id_nextpc),
    .index_i     (bus.if_id_instruc[25:0]),
    .dataa_i     (bus.rf_id_dataa),
    .datab_i     (bus.rf_id_datab),
    .pcimd2ext_o (pcimd2ext_s),
    .pcindex_o   (pcindex_s),
    .equal_o     (equal_s)
  );

  assign bus.id_rf_addra     = ADDR_W'(bus.if_id_instruc[25:21]);
  assign bus.id_rf_addrb     = ADDR_W'(bus.if_id_instruc[20:16]);
  assign bus.id_if_pcimd2ext = pcimd2ext_s;
  assign bus.id_if_pcindex   = pcindex_s;
  assign bus.id_if_rega      = bus.rf_id_dataa;

  // Instruction decode: would this instruction redirect, and how.
  always_comb begin
    dec_take_s = 1'b0;
    dec_type_s = PCSEL_BR;
    dec_link_s = 1'b0;
    dec_exc_s  = 1'b0;
    case (op_s)
      OP_BEQ: dec_take_s = equal_s;
      OP_BNE: dec_take_s = !equal_s;
      OP_J: begin
        dec_take_s = 1'b1;
        dec_type_s = PCSEL_IDX;
      end
      OP_JAL: begin
        dec_take_s = 1'b1;
        dec_type_s = PCSEL_IDX;
        dec_link_s = 1'b1;
      end
      OP_SPECIAL: begin
        if (funct_s == FN_JR) begin
          dec_take_s = 1'b1;
          dec_type_s = PCSEL_REG;
        end else if (funct_s == FN_SYSCALL) begin
          dec_take_s = 1'b1;
          dec_type_s = PCSEL_EXC;
          dec_exc_s  = 1'b1;
        end else begin
          dec_take_s = 1'b0;
        end
      end
      default: begin
        if (!op_known(op_s)) begin
          dec_take_s = 1'b1;
          dec_type_s = PCSEL_EXC;
          dec_exc_s  = 1'b1;
        end else begin
          dec_take_s = 1'b0;
        end
      end
    endcase
  end

  // Redirects are only issued from RUN, unstalled, out of reset, on a real instruction.
  always_comb begin
    redirect_ok_s = (state_q == ST_RUN) && !bus.ex_if_stall && !reset &&
                    (bus.if_id_instruc != NOP);
    selpcsource_s = dec_take_s && redirect_ok_s;
    if (selpcsource_s) begin
      selpctype_s = dec_type_s;
    end else begin
      selpctype_s = PCSEL_BR;
    end
  end

  assign bus.id_if_selpcsource = selpcsource_s;
  assign bus.id_if_selpctype   = selpctype_s;

  // FSM next state and ID/EX latch next values; a stall holds everything.
  always_comb begin
    state_d   = state_q;
    instruc_d = instruc_q;
    nextpc_d  = nextpc_q;
    link_d    = link_q;
    exc_d     = exc_q;
    if (!bus.ex_if_stall) begin
      case (state_q)
        ST_RUN: begin
          instruc_d = bus.if_id_instruc;
          nextpc_d  = bus.if_id_nextpc;
          link_d    = dec_link_s;
          exc_d     = dec_exc_s;
`ifdef ID_BRANCH_DELAY_SLOT_EN
          state_d   = ST_RUN;
`else
          state_d   = selpcsource_s ? ST_SQUASH : ST_RUN;
`endif
        end
        ST_SQUASH: begin
          instruc_d = NOP;
          nextpc_d  = bus.if_id_nextpc;
          link_d    = 1'b0;
          exc_d     = 1'b0;
          state_d   = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and ID/EX registers with synchronous reset taking priority over stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      instruc_q <= 32'h0000_0000;
      nextpc_q  <= 32'h0000_0000;
      link_q    <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      instruc_q <= instruc_d;
      nextpc_q  <= nextpc_d;
      link_q    <= link_d;
      exc_q     <= exc_d;
    end
  end

  assign bus.id_ex_instruc = instruc_q;
  assign bus.id_ex_nextpc  = nextpc_q;
  assign bus.id_ex_link    = link_q;
  assign bus.id_ex_exc     = exc_q;

endmodule
